// File: rtl/cache_ctrl_nway.sv
// N-way set-associative cache controller: hit/miss FSM, tree-PLRU victim, write-back/fill.
// Define CACHE_CTRL_NWAY_PERF_EN to add saturating hit/miss/writeback counters.
module cache_ctrl_nway #(
   parameter int unsigned ADDR_W   = 16,
   parameter int unsigned OFFSET_W = 4,
   parameter int unsigned SET_W    = 3,
   parameter int unsigned WAYS     = 4
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic [ADDR_W-1:0]                   mem_address,
   input  logic                                mem_read,
   input  logic                                mem_write,
   output logic                                mem_resp,
   input  logic [WAYS-1:0]                     hit,
   input  logic [WAYS-1:0]                     valid,
   input  logic [WAYS-1:0]                     dirty,
   output logic [ADDR_W-SET_W-OFFSET_W-1:0]    tag,
   output logic [SET_W-1:0]                    set_idx,
   output logic [OFFSET_W-1:0]                 offset,
   output logic [$clog2(WAYS)-1:0]             way_sel,
   output logic                                data_write,
   output logic                                line_fill,
   output logic                                tag_write,
   output logic                                valid_write,
   output logic                                dirty_write,
   output logic                                dirty_write_val,
   output logic                                pmem_read,
   output logic                                pmem_write,
   output logic [ADDR_W-1:0]                   pmem_address,
   input  logic                                pmem_resp
`ifdef CACHE_CTRL_NWAY_PERF_EN
   ,
   output logic [31:0]                         hit_count,
   output logic [31:0]                         miss_count,
   output logic [31:0]                         wb_count
`endif
);

   localparam int unsigned TAG_W = ADDR_W - SET_W - OFFSET_W;
   localparam int unsigned WAY_W = $clog2(WAYS);
   localparam int unsigned SETS  = 1 << SET_W;

   typedef enum logic [1:0] {IDLE, LOOKUP, WRITEBACK, FILL} state_e;

   state_e              state_q, state_d;
   logic [TAG_W-1:0]    tag_q, tag_d;
   logic [SET_W-1:0]    set_q, set_d;
   logic [OFFSET_W-1:0] off_q, off_d;
   logic                wr_q, wr_d;
   logic [WAY_W-1:0]    way_q, way_d;
   logic [WAYS-2:0]     plru_q [SETS];
   logic [WAYS-2:0]     plru_d [SETS];
   // Shadow of the tags this controller wrote, used to address write-backs.
   logic [TAG_W-1:0]    stag_q [SETS][WAYS];
   logic [TAG_W-1:0]    stag_d [SETS][WAYS];

   logic [WAY_W-1:0]    hit_way_c, inv_way_c, plru_way_c, victim_c;
   logic [WAYS-1:0]     tree_c, tree_upd_c;

   // Lowest hit way, lowest invalid way, PLRU walk and PLRU update for the hit way.
   always_comb begin : way_pick
      logic [WAY_W-1:0] node;
      hit_way_c  = '0;
      inv_way_c  = '0;
      for (int i = int'(WAYS) - 1; i >= 0; i--) begin
         if (hit[i])    hit_way_c = WAY_W'(i);
         if (!valid[i]) inv_way_c = WAY_W'(i);
      end
      tree_c     = {1'b0, plru_q[set_q]};
      plru_way_c = '0;
      node       = '0;
      for (int l = 0; l < int'(WAY_W); l++) begin
         plru_way_c[int'(WAY_W) - 1 - l] = tree_c[node];
         node = WAY_W'(2 * int'(node) + 1 + int'(tree_c[node]));
      end
      victim_c   = (~&valid) ? inv_way_c : plru_way_c;
      tree_upd_c = tree_c;
      node       = '0;
      for (int l = 0; l < int'(WAY_W); l++) begin
         tree_upd_c[node] = ~hit_way_c[int'(WAY_W) - 1 - l];
         node = WAY_W'(2 * int'(node) + 1 + int'(hit_way_c[int'(WAY_W) - 1 - l]));
      end
   end

   always_comb begin : fsm_next
      state_d         = state_q;
      tag_d           = tag_q;
      set_d           = set_q;
      off_d           = off_q;
      wr_d            = wr_q;
      way_d           = way_q;
      plru_d          = plru_q;
      stag_d          = stag_q;
      mem_resp        = 1'b0;
      data_write      = 1'b0;
      line_fill       = 1'b0;
      tag_write       = 1'b0;
      valid_write     = 1'b0;
      dirty_write     = 1'b0;
      dirty_write_val = 1'b0;
      pmem_read       = 1'b0;
      pmem_write      = 1'b0;
      pmem_address    = '0;
      tag             = tag_q;
      way_sel         = way_q;
      case (state_q)
         IDLE: begin
            if (mem_read || mem_write) begin
               tag_d   = mem_address[ADDR_W-1 -: TAG_W];
               set_d   = mem_address[OFFSET_W +: SET_W];
               off_d   = mem_address[OFFSET_W-1:0];
               wr_d    = mem_write & ~mem_read;
               state_d = LOOKUP;
            end
         end
         LOOKUP: begin
            way_sel = hit_way_c;
            if (|hit) begin
               mem_resp      = 1'b1;
               plru_d[set_q] = tree_upd_c[WAYS-2:0];
               if (wr_q) begin
                  data_write      = 1'b1;
                  dirty_write     = 1'b1;
                  dirty_write_val = 1'b1;
               end
               state_d = IDLE;
            end else begin
               way_d   = victim_c;
               state_d = (valid[victim_c] && dirty[victim_c]) ? WRITEBACK : FILL;
            end
         end
         WRITEBACK: begin
            tag          = stag_q[set_q][way_q];
            pmem_write   = 1'b1;
            pmem_address = {stag_q[set_q][way_q], set_q, OFFSET_W'(0)};
            if (pmem_resp) begin
               dirty_write = 1'b1;
               state_d     = FILL;
            end
         end
         FILL: begin
            pmem_read    = 1'b1;
            pmem_address = {tag_q, set_q, OFFSET_W'(0)};
            if (pmem_resp) begin
               line_fill            = 1'b1;
               tag_write            = 1'b1;
               valid_write          = 1'b1;
               dirty_write          = 1'b1;
               stag_d[set_q][way_q] = tag_q;
               state_d              = LOOKUP;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign set_idx = set_q;
   assign offset  = off_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         tag_q   <= '0;
         set_q   <= '0;
         off_q   <= '0;
         wr_q    <= 1'b0;
         way_q   <= '0;
         for (int s = 0; s < int'(SETS); s++) begin
            plru_q[s] <= '0;
            for (int w = 0; w < int'(WAYS); w++) stag_q[s][w] <= '0;
         end
      end else begin
         state_q <= state_d;
         tag_q   <= tag_d;
         set_q   <= set_d;
         off_q   <= off_d;
         wr_q    <= wr_d;
         way_q   <= way_d;
         plru_q  <= plru_d;
         stag_q  <= stag_d;
      end
   end

`ifdef CACHE_CTRL_NWAY_PERF_EN
   logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d, wb_cnt_q, wb_cnt_d;
   logic        hit_ev_c, miss_ev_c, wb_ev_c;

   // Saturating event counters.
   always_comb begin
      hit_ev_c   = (state_q == LOOKUP) && (|hit);
      miss_ev_c  = (state_q == LOOKUP) && !(|hit);
      wb_ev_c    = miss_ev_c && (state_d == WRITEBACK);
      hit_cnt_d  = hit_cnt_q  + 32'(hit_ev_c  && (hit_cnt_q  != '1));
      miss_cnt_d = miss_cnt_q + 32'(miss_ev_c && (miss_cnt_q != '1));
      wb_cnt_d   = wb_cnt_q   + 32'(wb_ev_c   && (wb_cnt_q   != '1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
         wb_cnt_q   <= '0;
      end else begin
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
         wb_cnt_q   <= wb_cnt_d;
      end
   end

   assign hit_count  = hit_cnt_q;
   assign miss_count = miss_cnt_q;
   assign wb_count   = wb_cnt_q;
`endif

endmodule

// File: tb/tb_cache_ctrl_nway.sv
// Directed bench for cache_ctrl_nway: acts as CPU, datapath arrays and memory.
module tb_cache_ctrl_nway;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] mem_address;
   logic        mem_read, mem_write, mem_resp;
   logic [3:0]  hit, valid, dirty;
   logic [8:0]  tag;
   logic [2:0]  set_idx;
   logic [3:0]  offset;
   logic [1:0]  way_sel;
   logic        data_write, line_fill, tag_write, valid_write, dirty_write, dirty_write_val;
   logic        pmem_read, pmem_write, pmem_resp;
   logic [15:0] pmem_address;
`ifdef CACHE_CTRL_NWAY_PERF_EN
   logic [31:0] hit_count, miss_count, wb_count;
`endif

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   cache_ctrl_nway dut (
      .clk(clk), .rst_n(rst_n),
      .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
      .hit(hit), .valid(valid), .dirty(dirty),
      .tag(tag), .set_idx(set_idx), .offset(offset), .way_sel(way_sel),
      .data_write(data_write), .line_fill(line_fill), .tag_write(tag_write),
      .valid_write(valid_write), .dirty_write(dirty_write), .dirty_write_val(dirty_write_val),
      .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
      .pmem_resp(pmem_resp)
`ifdef CACHE_CTRL_NWAY_PERF_EN
      , .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
`endif
   );

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic dp(input logic [3:0] h, input logic [3:0] v, input logic [3:0] d);
      hit = h; valid = v; dirty = d;
      #1;
   endtask

   // Present a request in IDLE; returns at the LOOKUP cycle.
   task automatic issue(input logic [15:0] a, input logic r, input logic w);
      mem_address = a; mem_read = r; mem_write = w; hit = '0;
      #1;
      chk("idle_no_resp", 32'(mem_resp), 32'd0);
      cyc();
   endtask

   task automatic done();
      cyc();
      mem_read = 1'b0; mem_write = 1'b0; hit = '0;
      #1;
      chk("resp_one_cycle", 32'(mem_resp), 32'd0);
   endtask

   task automatic fill_resp(input logic [1:0] w);
      pmem_resp = 1'b1;
      #1;
      chk("fill_line_fill", 32'(line_fill), 32'd1);
      chk("fill_tag_valid", 32'({tag_write, valid_write}), 32'd3);
      chk("fill_dirty_clr", 32'({dirty_write, dirty_write_val}), 32'd2);
      chk("fill_way", 32'(way_sel), 32'(w));
      cyc();
      pmem_resp = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; mem_address = '0; mem_read = 1'b0; mem_write = 1'b0;
      hit = '0; valid = '0; dirty = '0; pmem_resp = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_strobes", 32'({mem_resp, pmem_read, pmem_write, data_write, line_fill}), 32'd0);
      chk("rst_pmem_addr", 32'(pmem_address), 32'd0);
      chk("rst_latched", 32'({tag, set_idx, offset, way_sel}), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Read miss into empty cache, fill on way 0, then hit.
      issue(16'h0040, 1'b1, 1'b0);
      dp(4'b0000, 4'b0000, 4'b0000);
      chk("miss_no_resp", 32'(mem_resp), 32'd0);
      cyc();
      chk("fill_pmem_read", 32'({pmem_read, pmem_write}), 32'd2);
      chk("fill_addr_040", 32'(pmem_address), 32'h0040);
      cyc();
      chk("fill_hold", 32'(pmem_read), 32'd1);
      fill_resp(2'd0);
      dp(4'b0001, 4'b0001, 4'b0000);
      chk("refill_hit_resp", 32'(mem_resp), 32'd1);
      done();

      // Write hit on way 2, set 3.
      issue(16'h02B4, 1'b0, 1'b1);
      dp(4'b0100, 4'b1111, 4'b0000);
      chk("wr_hit_resp", 32'(mem_resp), 32'd1);
      chk("wr_hit_dw", 32'({data_write, dirty_write, dirty_write_val}), 32'd7);
      chk("wr_hit_way", 32'(way_sel), 32'd2);
      chk("wr_hit_addr", 32'({tag, set_idx, offset}), 32'({9'h005, 3'd3, 4'd4}));
      done();

      // Several hit bits: lowest wins; read has no array writes.
      issue(16'h02B0, 1'b1, 1'b0);
      dp(4'b1100, 4'b1111, 4'b0000);
      chk("multi_hit_way", 32'(way_sel), 32'd2);
      chk("rd_hit_no_dw", 32'({data_write, dirty_write}), 32'd0);
      done();

      // Both strobes: treated as read.
      issue(16'h02B0, 1'b1, 1'b1);
      dp(4'b0100, 4'b1111, 4'b0000);
      chk("both_resp", 32'(mem_resp), 32'd1);
      chk("both_no_write", 32'({data_write, dirty_write}), 32'd0);
      done();

      // Hits to ways 0..3 in set 2, then a miss: PLRU victim is way 0.
      for (int i = 0; i < 4; i++) begin
         issue(16'h00A0, 1'b1, 1'b0);
         dp(4'(1 << i), 4'b1111, 4'b0000);
         chk("seq_hit_way", 32'(way_sel), 32'(i));
         done();
      end
      issue(16'h01A0, 1'b1, 1'b0);
      dp(4'b0000, 4'b1111, 4'b0000);
      cyc();
      chk("plru_victim", 32'(way_sel), 32'd0);
      chk("plru_fill_addr", 32'(pmem_address), 32'h01A0);
      fill_resp(2'd0);
      dp(4'b0001, 4'b1111, 4'b0000);
      chk("plru_refill_resp", 32'(mem_resp), 32'd1);
      done();

      // Set 5: install tag 0x1A in way 1, steer PLRU to way 1, then dirty eviction.
      issue(16'h0D50, 1'b1, 1'b0);
      dp(4'b0000, 4'b0001, 4'b0000);
      cyc();
      chk("inv_victim_way", 32'(way_sel), 32'd1);
      fill_resp(2'd1);
      dp(4'b0010, 4'b0011, 4'b0000);
      done();
      issue(16'h0050, 1'b1, 1'b0);
      dp(4'b0001, 4'b1111, 4'b0010);
      done();
      issue(16'h0150, 1'b1, 1'b0);
      dp(4'b0100, 4'b1111, 4'b0010);
      done();
      issue(16'h01D0, 1'b0, 1'b1);
      dp(4'b0000, 4'b1111, 4'b0010);
      cyc();
      chk("wb_strobes", 32'({pmem_read, pmem_write}), 32'd1);
      chk("wb_addr", 32'(pmem_address), 32'h0D50);
      chk("wb_victim_tag", 32'(tag), 32'h01A);
      chk("wb_way", 32'(way_sel), 32'd1);
      pmem_resp = 1'b1;
      #1;
      chk("wb_dirty_clr", 32'({dirty_write, dirty_write_val, line_fill}), 32'd4);
      cyc();
      pmem_resp = 1'b0;
      #1;
      chk("wb_fill_strobes", 32'({pmem_read, pmem_write}), 32'd2);
      chk("wb_fill_addr", 32'(pmem_address), 32'h01D0);
      chk("wb_fill_tag", 32'(tag), 32'h003);
      fill_resp(2'd1);
      dp(4'b0010, 4'b1111, 4'b0000);
      chk("wb_final_hit", 32'({mem_resp, data_write, way_sel}), 32'({1'b1, 1'b1, 2'd1}));
      done();
`ifdef CACHE_CTRL_NWAY_PERF_EN
      chk("wb_count", wb_count, 32'd1);
`endif

      // Reset during FILL drops pmem_read at once and blocks array writes.
      issue(16'h0300, 1'b1, 1'b0);
      dp(4'b0000, 4'b0000, 4'b0000);
      cyc();
      chk("pre_rst_fill", 32'(pmem_read), 32'd1);
      rst_n = 1'b0;
      pmem_resp = 1'b1;
      #1;
      chk("rst_drop_pmem", 32'({pmem_read, pmem_write}), 32'd0);
      chk("rst_drop_addr", 32'(pmem_address), 32'd0);
      chk("rst_no_writes", 32'({line_fill, tag_write, valid_write, dirty_write}), 32'd0);
      cyc();
      pmem_resp = 1'b0; mem_read = 1'b0;
      rst_n = 1'b1;
      cyc();
      chk("post_rst_latched", 32'({tag, set_idx, way_sel}), 32'd0);
`ifdef CACHE_CTRL_NWAY_PERF_EN
      chk("post_rst_counts", hit_count | miss_count | wb_count, 32'd0);
`endif
      // PLRU cleared: set 2 victim back to way 0.
      issue(16'h02A0, 1'b1, 1'b0);
      dp(4'b0000, 4'b1111, 4'b0000);
      cyc();
      chk("post_rst_victim", 32'(way_sel), 32'd0);
      fill_resp(2'd0);
      dp(4'b0001, 4'b1111, 4'b0000);
      chk("post_rst_resp", 32'(mem_resp), 32'd1);
      done();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
